dense_bias_loader: RTL and testbench
====================================

// Module: dense_bias_loader
// PURPOSE
//  Write side of the dense-layer bias store. Receives bias words as a byte
//  stream over a valid/ready handshake and assembles them MSB-first into
//  LENGTH_SIZE words. Writes each word into an internal register file.
//  Exposes the same combinational adr -> dataOut read port the dense layer
//  already uses for its bias lookup, so it replaces the constant table at
//  run time.
// PARAMETERS
//  WORD_SIZE   32  bias word width in bits; must be a multiple of 8
//  LENGTH_SIZE 10  number of bias words (one per output neuron)
//  ADR_SIZE    4   read/write address width; 2**ADR_SIZE >= LENGTH_SIZE
// PORTS
//  clk      in   1          system clock, rising edge
//  rstN     in   1          asynchronous reset, active low
//  start    in   1          1-cycle pulse: begin a (re)load of all words
//  inValid  in   1          byte on inData is valid
//  inData   in   8          stream byte, MSB of each word first
//  inReady  out  1          loader accepts a byte this cycle
//  busy     out  1          load in progress
//  done     out  1          all words loaded; held until next start
//  chkErr   out  1          checksum mismatch (BIAS_CHECKSUM_EN only)
//  adr      in   ADR_SIZE   read address from dense layer
//  dataOut  out  WORD_SIZE  bias word at adr (combinational)
// BEHAVIOUR
//  - Reset (rstN=0, async): state IDLE; byteCnt, wordCnt and shift reg = 0.
//    All mem words = 0. inReady = busy = done = chkErr = 0.
//  - FSM states: IDLE -> LOAD on start.
//    LOAD -> DONE after the last byte of word LENGTH_SIZE-1.
//    With BIAS_CHECKSUM_EN, that last byte moves LOAD -> CHECK instead, and
//    CHECK -> DONE after the checksum word. DONE -> LOAD on start.
//  - start in any state (LOAD or CHECK included) clears byteCnt, wordCnt,
//    done and chkErr, and enters LOAD on the next edge. start does not clear
//    mem contents. A byte presented in the same cycle as start is not
//    accepted.
//  - inReady = 1 only in LOAD and CHECK. A byte transfers on an edge where
//    inValid && inReady. inValid gaps stall assembly indefinitely; there is
//    no timeout.
//  - Assembly: shift <= {shift[WORD_SIZE-9:0], inData}. On byte
//    WORD_SIZE/8-1, mem[wordCnt] <= {shift[WORD_SIZE-9:0], inData} at that
//    edge, wordCnt increments and byteCnt wraps to 0.
//  - done rises on the edge that writes the final word (or the checksum
//    word). It is visible on the following cycle. busy = (state != IDLE &&
//    state != DONE).
//  - Read: dataOut = mem[adr] for adr < LENGTH_SIZE, otherwise 0.
//    Zero-latency, so a read during a load returns the current, partially
//    updated contents. A read of the word being written returns the old
//    value until the write edge.
// CONFIGURATION
//  BIAS_CHECKSUM_EN defined:
//  - A running sum (mod 2**WORD_SIZE) of all LENGTH_SIZE bias words is kept.
//  - One extra WORD_SIZE-bit word is then received in CHECK.
//  - chkErr = 1 if that word differs from the sum. It is set with done and
//    held until start or reset. The checksum word is never written to mem.
//  BIAS_CHECKSUM_EN undefined:
//  - No CHECK state and no sum register. chkErr is tied to 0.
// TESTING
//  - Reset mid-load (after 5 bytes), release -> every adr reads 0;
//    inReady/busy/done = 0.
//  - start, then 40 bytes beginning 01 25 98 B0 0B 1A 26 D0 ... ->
//    adr=0 reads 0x012598B0, adr=1 reads 0x0B1A26D0; done=1 one cycle after
//    byte 40.
//  - Same load with inValid toggled randomly (50%) -> identical mem
//    contents; no byte dropped or duplicated.
//  - start pulsed after word 3 of a load -> wordCnt restarts at 0; the full
//    new 40-byte stream overwrites words 0-9.
//  - adr = 10..15 -> dataOut = 0 both during and after a load.
//  - BIAS_CHECKSUM_EN: correct sum word -> done=1, chkErr=0. Sum+1 ->
//    done=1, chkErr=1. Next start clears chkErr.

Source files
------------

// File: rtl/dense_bias_loader_if.sv
// Byte-stream port of the bias loader: a producer pushes bias bytes MSB-first.
// Handshake: a byte moves on a rising clk edge where inValid && inReady; inData must hold while inValid waits.
interface dense_bias_loader_if;
    logic       inValid;
    logic [7:0] inData;
    logic       inReady;

    modport master (output inValid, output inData, input inReady);
    modport slave  (input inValid, input inData, output inReady);
endinterface

// File: rtl/dense_bias_loader.sv
// Write side of the dense-layer bias store: assembles streamed bytes into words and serves a combinational read port.
// Optional feature macro: BIAS_CHECKSUM_EN (trailing sum word, chkErr flag).
module dense_bias_loader #(
    parameter int WORD_SIZE   = 32,
    parameter int LENGTH_SIZE = 10,
    parameter int ADR_SIZE    = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    dense_bias_loader_if.slave   stream,
    output logic                 busy,
    output logic                 done,
    output logic                 chkErr,
    input  logic [ADR_SIZE-1:0]  adr,
    output logic [WORD_SIZE-1:0] dataOut,
    output logic [1:0]           stateDbg
);

    localparam int BYTES = WORD_SIZE / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = ADR_SIZE + 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(LENGTH_SIZE - 1);
    localparam logic [WCW-1:0] NUM_WORDS = WCW'(LENGTH_SIZE);

`ifdef BIAS_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t                 state;
    state_t                 next_state;
    logic [BCW-1:0]         byteCnt;
    logic [WCW-1:0]         wordCnt;
    logic [WORD_SIZE-1:0]   shift;
    logic [WORD_SIZE-1:0]   mem [LENGTH_SIZE];
    logic [WORD_SIZE-1:0]   word_in;
    logic                   accept;
    logic                   word_end;
    logic                   last_word;
`ifdef BIAS_CHECKSUM_EN
    logic [WORD_SIZE-1:0]   sum;
`endif

    // A byte offered alongside start is refused so the new load begins cleanly.
`ifdef BIAS_CHECKSUM_EN
    assign stream.inReady = (state == LOAD || state == CHECK) && !start;
`else
    assign stream.inReady = (state == LOAD) && !start;
`endif

    assign accept    = stream.inValid && stream.inReady;
    assign word_in   = {shift[WORD_SIZE-9:0], stream.inData};
    assign word_end  = accept && (byteCnt == LAST_BYTE);
    assign last_word = word_end && (state == LOAD) && (wordCnt == LAST_WORD);
    assign busy      = (state != IDLE) && (state != DONE);
    assign stateDbg  = state;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (last_word) begin
`ifdef BIAS_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = DONE;
`endif
                    end
                end
`ifdef BIAS_CHECKSUM_EN
                CHECK: begin
                    if (word_end) begin
                        next_state = DONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            byteCnt <= '0;
            wordCnt <= '0;
            shift   <= '0;
            done    <= 1'b0;
            chkErr  <= 1'b0;
            for (int i = 0; i < LENGTH_SIZE; i++) begin
                mem[i] <= '0;
            end
`ifdef BIAS_CHECKSUM_EN
            sum     <= '0;
`endif
        end else if (start) begin
            // Restart keeps mem; only the assembly position and flags reset.
            byteCnt <= '0;
            wordCnt <= '0;
            shift   <= '0;
            done    <= 1'b0;
            chkErr  <= 1'b0;
`ifdef BIAS_CHECKSUM_EN
            sum     <= '0;
`endif
        end else if (accept) begin
            shift <= word_in;
            if (byteCnt == LAST_BYTE) begin
                byteCnt <= '0;
                if (state == LOAD) begin
                    mem[wordCnt[ADR_SIZE-1:0]] <= word_in;
                    wordCnt <= wordCnt + 1'b1;
`ifdef BIAS_CHECKSUM_EN
                    sum <= sum + word_in;
`else
                    if (last_word) begin
                        done <= 1'b1;
                    end
`endif
                end
`ifdef BIAS_CHECKSUM_EN
                else begin
                    chkErr <= (word_in != sum);
                    done   <= 1'b1;
                end
`endif
            end else begin
                byteCnt <= byteCnt + 1'b1;
            end
        end
    end

    always_comb begin
        dataOut = '0;
        if ({1'b0, adr} < NUM_WORDS) begin
            dataOut = mem[adr];
        end
    end

endmodule

// File: tb/tb_dense_bias_loader.sv
// Self-checking bench for dense_bias_loader: random byte streams against a word-array reference model.
// Define BIAS_CHECKSUM_EN for both bench and RTL to exercise the checksum path.
module tb_dense_bias_loader;
    localparam int WS = 32;
    localparam int LS = 10;
    localparam int AS = 4;
    localparam int NB = (WS / 8) * LS;
`ifdef BIAS_CHECKSUM_EN
    localparam int NBT = NB + WS / 8;
`else
    localparam int NBT = NB;
`endif

    logic          clk;
    logic          rstN;
    logic          start;
    logic [AS-1:0] adr;
    logic [WS-1:0] dataOut;
    logic          busy;
    logic          done;
    logic          chkErr;
    logic [1:0]    stateDbg;

    dense_bias_loader_if stream();

    dense_bias_loader #(.WORD_SIZE(WS), .LENGTH_SIZE(LS), .ADR_SIZE(AS)) dut (
        .clk(clk), .rstN(rstN), .start(start), .stream(stream),
        .busy(busy), .done(done), .chkErr(chkErr),
        .adr(adr), .dataOut(dataOut), .stateDbg(stateDbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0]    bytes_q[$];
    logic [WS-1:0] exp_mem [LS];

    function automatic logic [WS-1:0] model_word(input int k);
        logic [WS-1:0] w = '0;
        for (int j = 0; j < WS / 8; j++) w = (w << 8) | WS'(bytes_q[k * (WS / 8) + j]);
        return w;
    endfunction

    // Builds a 40-byte stream (optionally with the known prefix) plus the sum word when enabled.
    task automatic build_stream(input bit known, input bit bad_sum);
        logic [WS-1:0] s;
        bytes_q.delete();
        if (known) begin
            bytes_q.push_back(8'h01); bytes_q.push_back(8'h25);
            bytes_q.push_back(8'h98); bytes_q.push_back(8'hB0);
            bytes_q.push_back(8'h0B); bytes_q.push_back(8'h1A);
            bytes_q.push_back(8'h26); bytes_q.push_back(8'hD0);
        end
        while (bytes_q.size() < NB) bytes_q.push_back(8'($urandom));
        s = '0;
        for (int k = 0; k < LS; k++) s = s + model_word(k);
        if (bad_sum) s = s + 1;
        if (NBT > NB) begin
            for (int j = WS / 8 - 1; j >= 0; j--) bytes_q.push_back(8'(s >> (8 * j)));
        end
    endtask

    task automatic read_adr(input int a, output logic [WS-1:0] v);
        adr = a[AS-1:0];
        #1;
        v = dataOut;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int waited = 0;
        ok = 1'b0;
        @(negedge clk);
        stream.inValid = 1'b1;
        stream.inData  = b;
        #1;
        while (!stream.inReady && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (stream.inReady) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
        stream.inValid = 1'b0;
        stream.inData  = 8'($urandom);
    endtask

    task automatic pulse_start(input bit junk);
        @(negedge clk);
        start = 1'b1;
        if (junk) begin
            stream.inValid = 1'b1;
            stream.inData  = 8'hEE;
        end
        #1;
        if (junk) begin
            checks++;
            if (stream.inReady !== 1'b0) begin
                errors++;
                $display("FAIL start_ready: inReady=%b required=0", stream.inReady);
            end
        end
        @(negedge clk);
        start = 1'b0;
        stream.inValid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || chkErr !== 1'b0) begin
            errors++;
            $display("FAIL after_start: busy=%b done=%b chkErr=%b required 1/0/0", busy, done, chkErr);
        end
    endtask

    // Sends bytes_q[first +: n]; word updates go to the model as each word completes.
    task automatic send_stream(input int first, input int n, input bit gaps, input bit check_reads);
        bit ok;
        logic [WS-1:0] v;
        logic [WS-1:0] e;
        for (int i = first; i < first + n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            if (check_reads && (i % 4 == 3) && (i / 4 < LS)) begin
                read_adr(i / 4, v);
                checks++;
                if (v !== exp_mem[i / 4]) begin
                    errors++;
                    $display("FAIL old_word_read: adr=%0d got=%h required=%h", i / 4, v, exp_mem[i / 4]);
                end
            end
            send_byte(bytes_q[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL byte_timeout: byte=%0d accepted=0 required=1", i);
            end
            if ((i + 1) % 4 == 0 && (i + 1) / 4 - 1 < LS) begin
                exp_mem[(i + 1) / 4 - 1] = model_word((i + 1) / 4 - 1);
                if (check_reads) begin
                    for (int a = 0; a < 16; a++) begin
                        read_adr(a, v);
                        e = (a < LS) ? exp_mem[a] : '0;
                        checks++;
                        if (v !== e) begin
                            errors++;
                            $display("FAIL partial_read: adr=%0d got=%h required=%h", a, v, e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < LS; k++) exp_mem[k] = '0;
    endtask

    task automatic test_reset();
        logic [WS-1:0] v;
        rstN = 1'b1; start = 1'b0; adr = '0;
        stream.inValid = 1'b0; stream.inData = 8'h00;
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stream.inReady !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || chkErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b busy=%b done=%b chkErr=%b required all 0",
                     stream.inReady, busy, done, chkErr);
        end
        rstN = 1'b1;
        for (int k = 0; k < LS; k++) exp_mem[k] = '0;
        build_stream(1'b1, 1'b0);
        pulse_start(1'b0);
        send_stream(0, 5, 1'b0, 1'b0);
        read_adr(0, v);
        checks++;
        if (v !== 32'h012598B0) begin
            errors++;
            $display("FAIL pre_reset_word0: got=%h required=012598b0", v);
        end
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (stream.inReady !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_flags: ready=%b busy=%b done=%b required 0/0/0", stream.inReady, busy, done);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < LS; k++) exp_mem[k] = '0;
        for (int a = 0; a < 16; a++) begin
            read_adr(a, v);
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_mem: adr=%0d got=%h required=0", a, v);
            end
        end
    endtask

    task automatic check_loaded(input string tag, input bit exp_err);
        logic [WS-1:0] v;
        logic [WS-1:0] e;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || stream.inReady !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b ready=%b required 1/0/0", tag, done, busy, stream.inReady);
        end
        checks++;
        if (chkErr !== exp_err) begin
            errors++;
            $display("FAIL %s_chkerr: got=%b required=%b", tag, chkErr, exp_err);
        end
        for (int a = 0; a < 16; a++) begin
            read_adr(a, v);
            e = (a < LS) ? exp_mem[a] : '0;
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL %s_mem: adr=%0d got=%h required=%h", tag, a, v, e);
            end
        end
    endtask

    task automatic test_known_load();
        logic [WS-1:0] v;
        build_stream(1'b1, 1'b0);
        pulse_start(1'b0);
        send_stream(0, NBT - 1, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_done: done=%b busy=%b required 0/1", done, busy);
        end
        send_stream(NBT - 1, 1, 1'b0, 1'b0);
        check_loaded("known", 1'b0);
        read_adr(0, v);
        checks++;
        if (v !== 32'h012598B0) begin
            errors++;
            $display("FAIL known_word0: got=%h required=012598b0", v);
        end
        read_adr(1, v);
        checks++;
        if (v !== 32'h0B1A26D0) begin
            errors++;
            $display("FAIL known_word1: got=%h required=0b1a26d0", v);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        pulse_start(1'b0);
        send_stream(0, NBT, 1'b1, 1'b0);
        check_loaded("gaps", 1'b0);
    endtask

    task automatic test_restart();
        build_stream(1'b0, 1'b0);
        pulse_start(1'b0);
        send_stream(0, 18, 1'b1, 1'b1);
        pulse_start(1'b1);
        build_stream(1'b0, 1'b0);
        send_stream(0, NBT, 1'b0, 1'b1);
        check_loaded("restart", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            build_stream(1'b0, 1'b0);
            pulse_start(1'b0);
            send_stream(0, NBT, 1'b0, 1'b0);
            check_loaded("b2b", 1'b0);
        end
    endtask

`ifdef BIAS_CHECKSUM_EN
    task automatic test_checksum();
        build_stream(1'b0, 1'b1);
        pulse_start(1'b0);
        send_stream(0, NBT, 1'b1, 1'b0);
        check_loaded("bad_sum", 1'b1);
        pulse_start(1'b0);
        build_stream(1'b0, 1'b0);
        send_stream(0, NBT, 1'b0, 1'b0);
        check_loaded("good_sum", 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_load();
        test_gaps();
        test_restart();
        test_back_to_back();
`ifdef BIAS_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
